revenantx86_fifo_delay: RTL and testbench
=========================================

# revenantx86_fifo_delay

Eight-entry, 8-bit FIFO with a programmable minimum residence time: an entry cannot be read until it has been stored for at least `delay` clock cycles. It is the core of the TinyTapeout user tile, mapped directly onto the standard `ui_in`/`uo_out`/`uio_*` pins, with a single clock domain. Host logic or the test bench drives write, read, configure and clear strobes on the bidirectional pins and observes data and status on the outputs.

## Interface
Parameters: none. Depth is fixed at 8, width at 8, and age/delay fields at 4 bits.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: tile enable; ignored, the design always runs.
- `ui_in` in 8: write data; also the configuration value (bits [3:0]) when `cfg` is high.
- `uio_in` in 8: [0] `wr`, [1] `rd`, [2] `cfg`, [3] `clr`; [7:4] ignored.
- `uo_out` out 8: last read data, registered.
- `uio_out` out 8: [3:0] = 0, [4] `full`, [5] `empty`, [6] `ready`, [7] `rd_valid`.
- `uio_oe` out 8: constant 8'hF0.

## Operation
- **Storage:** 8 slots, each holding 8-bit data plus a 4-bit age. There are 3-bit read and write pointers that wrap 7→0, and a 4-bit count from 0 to 8.
- **Delay register:** 4 bits, reset value 4.
- **Priority per edge:** `clr` > `cfg` > (`wr`, `rd`).
- **Clear (`clr`=1):** pointers and count go to 0. `delay`, `uo_out` and stored data are unchanged. `rd_valid` goes to 0. `wr`/`rd`/`cfg` are ignored that cycle.
- **Configure (`cfg`=1, `clr`=0):** `delay` ← `ui_in[3:0]`. A write that cycle is dropped; a read that cycle is still processed. The new delay applies immediately to all stored entries.
- **Write:**
  - Accepted when `wr`=1 and `full`=0.
  - The slot at the write pointer gets `ui_in` with age 0; the write pointer increments.
  - A write while full is dropped, even if a read pops the same cycle.
- **Read:**
  - Accepted when `rd`=1 and `ready`=1.
  - `uo_out` ← head data; the read pointer increments; `rd_valid` ← 1 for that one cycle.
  - Otherwise `rd_valid` ← 0 and `uo_out` holds its value.
  - A read while not ready is ignored, with no error flag.
- **Simultaneous write and read:** both are accepted (when not full and ready); count is unchanged.
- **Aging:** every edge, each occupied slot not written that edge has its age incremented, saturating at 15.
- **Status** (combinational from registers):
  - `full` = (count == 8)
  - `empty` = (count == 0)
  - `ready` = !empty && age[head] ≥ delay

## Timing
- **Reset values:**
  - `uo_out` = 0, `rd_valid` = 0, `full` = 0, `empty` = 1, `ready` = 0
  - `delay` = 4, pointers and count = 0
  - `uio_out[3:0]` = 0, `uio_oe` = F0
- **Write latency:**
  - A write accepted at edge E gives age 0 after E and age k after edge E+k.
  - With delay D, `ready` is high in the cycle after edge E+D.
  - With D=0, `ready` is high in the cycle right after E.
- **Read latency:** a read accepted at edge R shows data on `uo_out` and `rd_valid`=1 right after R.
- **Minimum write-to-output:** D+1 edges.
- **FIFO order:** readiness is checked only at the head, so a later entry is never read before an earlier one. Entries are written in order and the head is always the oldest, so readiness is monotone along the queue.
- **Count rules:** increments on write-only, decrements on read-only, unchanged on both or neither. It never exceeds 8 or goes below 0.
- **Reset mid-operation:** takes effect immediately (asynchronous) and the FIFO returns to reset state.

## Test plan
- **Reset defaults:** apply reset → `uo_out`=00, `uio_out`=8'h20 (only `empty` set), `uio_oe`=F0.
- **Default delay of 4:** write A5 at edge E, then hold `rd`=1 → `ready` rises after edge E+4. The first accepted read yields `uo_out`=A5 with a single-cycle `rd_valid`.
- **Delay 0:** `cfg` with `ui_in`=00, write 11, 22, 33 on consecutive edges, then read continuously → outputs 11, 22, 33 on consecutive cycles, then `empty`=1 and `ready`=0.
- **Full:** with delay 15, write 01..09 → after 8 writes `full`=1. Entry 09 is dropped and count stays 8. After draining, the data read is 01..08 only.
- **Simultaneous write and read:** FIFO holding 3 ready entries, `wr`+`rd` together on one edge → count stays 3, the head is output, and the new entry lands at the tail. Verify pointer wrap by cycling 20 entries through.
- **Clear and configure priority:** with the FIFO holding 4 entries, assert `clr`+`wr`+`cfg` together → `empty`=1, `delay` unchanged, `uo_out` unchanged.

Source files
------------

// File: rtl/revenantx86_fifo_delay_if.sv
// Pin bundle of the TinyTapeout user tile as seen by the delay FIFO.
//   ui_in   : write data / configuration value
//   uio_in  : [0] wr, [1] rd, [2] cfg, [3] clr, [7:4] unused
//   uo_out  : last read data (registered)
//   uio_out : [4] full, [5] empty, [6] ready, [7] rd_valid, [3:0] zero
//   uio_oe  : output enables for uio pins
// The master modport is the host side; the slave modport is the FIFO.
interface revenantx86_fifo_delay_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/revenantx86_fifo_delay.sv
// Eight-entry, 8-bit FIFO whose entries only become readable after they have
// been stored for at least `delay` cycles. Each slot carries a saturating
// 4-bit age; readiness is judged only at the head so FIFO order is preserved.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   ena   : tile enable, ignored
//   bus   : tile pins (see revenantx86_fifo_delay_if)
module revenantx86_fifo_delay (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  revenantx86_fifo_delay_if.slave         bus
);

  localparam int unsigned Depth = 8;

  logic [7:0] data_q [Depth];
  logic [3:0] age_q  [Depth];
  logic [2:0] rd_ptr_q, wr_ptr_q;
  logic [3:0] count_q, count_d;
  logic [3:0] delay_q;
  logic [7:0] uo_q;
  logic       rd_valid_q;

  logic wr, rd, cfg, clr;
  logic full, empty, ready;
  logic wr_ok, rd_ok;
  logic [Depth-1:0] occupied;

  logic unused_pins;
  assign unused_pins = &{1'b0, ena, bus.uio_in[7:4]};

  assign wr  = bus.uio_in[0];
  assign rd  = bus.uio_in[1];
  assign cfg = bus.uio_in[2];
  assign clr = bus.uio_in[3];

  assign full  = (count_q == 4'd8);
  assign empty = (count_q == 4'd0);
  assign ready = !empty && (age_q[rd_ptr_q] >= delay_q);

  // cfg steals the write but still lets a read through; clr blocks both.
  assign wr_ok = wr && !full && !cfg && !clr;
  assign rd_ok = rd && ready && !clr;

  assign count_d = count_q + {3'b000, wr_ok} - {3'b000, rd_ok};

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < Depth; i++) begin
      logic [2:0] off;
      off = 3'(i) - rd_ptr_q;
      occupied[i] = ({1'b0, off} < count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= 8'h00;
        age_q[i]  <= 4'h0;
      end
      rd_ptr_q   <= 3'd0;
      wr_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
      delay_q    <= 4'd4;
      uo_q       <= 8'h00;
      rd_valid_q <= 1'b0;
    end else if (clr) begin
      rd_ptr_q   <= 3'd0;
      wr_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
      rd_valid_q <= 1'b0;
    end else begin
      if (cfg) begin
        delay_q <= bus.ui_in[3:0];
      end
      for (int i = 0; i < Depth; i++) begin
        if (wr_ok && (wr_ptr_q == 3'(i))) begin
          data_q[i] <= bus.ui_in;
          age_q[i]  <= 4'h0;
        end else if (occupied[i] && (age_q[i] != 4'hF)) begin
          age_q[i] <= age_q[i] + 4'h1;
        end
      end
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 3'd1;
      end
      if (rd_ok) begin
        uo_q     <= data_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 3'd1;
      end
      rd_valid_q <= rd_ok;
      count_q    <= count_d;
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = {rd_valid_q, ready, empty, full, 4'b0000};
  assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_revenantx86_fifo_delay.sv
module tb_revenantx86_fifo_delay;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;

  revenantx86_fifo_delay_if bus ();

  revenantx86_fifo_delay dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of entries stamped with the edge that wrote them.
  typedef struct {
    logic [7:0] d;
    int         t;
  } ent_t;

  ent_t       mq[$];
  int         edge_n;
  logic [3:0] m_delay;
  logic [7:0] m_uo;
  logic       m_rdv;

  function automatic void model_reset();
    mq.delete();
    edge_n  = 0;
    m_delay = 4'd4;
    m_uo    = 8'h00;
    m_rdv   = 1'b0;
  endfunction

  function automatic logic model_ready();
    int age;
    if (mq.size() == 0) return 1'b0;
    age = edge_n - mq[0].t;
    if (age > 15) age = 15;
    return age >= int'(m_delay);
  endfunction

  function automatic logic [7:0] model_uio();
    return {m_rdv, model_ready(), mq.size() == 0, mq.size() == 8, 4'b0000};
  endfunction

  function automatic void model_step(logic wr, logic rd, logic cfg, logic clr,
                                     logic [7:0] din);
    logic was_full;
    logic rdy;
    ent_t e;
    if (clr) begin
      mq.delete();
      m_rdv = 1'b0;
    end else begin
      was_full = (mq.size() == 8);
      rdy      = model_ready();
      if (rd && rdy) begin
        e     = mq.pop_front();
        m_uo  = e.d;
        m_rdv = 1'b1;
      end else begin
        m_rdv = 1'b0;
      end
      if (cfg) begin
        m_delay = din[3:0];
      end else if (wr && !was_full) begin
        e.d = din;
        e.t = edge_n + 1;
        mq.push_back(e);
      end
    end
    edge_n++;
  endfunction

  function automatic void check8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endfunction

  task automatic compare_model(string tag);
    check8({tag, " uo_out"}, bus.uo_out, m_uo);
    check8({tag, " uio_out"}, bus.uio_out, model_uio());
    check8({tag, " uio_oe"}, bus.uio_oe, 8'hF0);
  endtask

  // Drive one edge's worth of strobes, advance the model, compare after the edge.
  task automatic apply(logic wr, logic rd, logic cfg, logic clr, logic [7:0] din,
                       string tag);
    @(negedge clk);
    bus.ui_in  = din;
    bus.uio_in = {4'h0, clr, cfg, rd, wr};
    @(posedge clk);
    model_step(wr, rd, cfg, clr, din);
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    logic       wr, rd, cfg, clr;
    logic [7:0] din;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic wr, logic rd, logic cfg, logic clr, logic [7:0] din,
                              logic [7:0] exp_uo, logic [7:0] exp_uio);
    vec_t v;
    v.wr = wr; v.rd = rd; v.cfg = cfg; v.clr = clr;
    v.din = din; v.exp_uo = exp_uo; v.exp_uio = exp_uio;
    return v;
  endfunction

  logic [7:0] got[$];

  initial begin
    // Default delay 4: A5 becomes ready after the fourth edge following its write.
    tbl[0]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h20);
    tbl[1]  = mk(1, 0, 0, 0, 8'hA5, 8'h00, 8'h00);
    tbl[2]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    tbl[3]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    tbl[4]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    tbl[5]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h40);
    tbl[6]  = mk(0, 1, 0, 0, 8'h00, 8'hA5, 8'hA0);
    tbl[7]  = mk(0, 1, 0, 0, 8'h00, 8'hA5, 8'h20);
    // Delay 0: back-to-back writes then back-to-back reads.
    tbl[8]  = mk(0, 0, 1, 0, 8'h00, 8'hA5, 8'h20);
    tbl[9]  = mk(1, 0, 0, 0, 8'h11, 8'hA5, 8'h40);
    tbl[10] = mk(1, 0, 0, 0, 8'h22, 8'hA5, 8'h40);
    tbl[11] = mk(1, 0, 0, 0, 8'h33, 8'hA5, 8'h40);
    tbl[12] = mk(0, 1, 0, 0, 8'h00, 8'h11, 8'hC0);
    tbl[13] = mk(0, 1, 0, 0, 8'h00, 8'h22, 8'hC0);
    tbl[14] = mk(0, 1, 0, 0, 8'h00, 8'h33, 8'hA0);
    tbl[15] = mk(0, 1, 0, 0, 8'h00, 8'h33, 8'h20);

    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    model_reset();
    #2;
    check8("reset uo_out", bus.uo_out, 8'h00);
    check8("reset uio_out", bus.uio_out, 8'h20);
    check8("reset uio_oe", bus.uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].wr, tbl[i].rd, tbl[i].cfg, tbl[i].clr, tbl[i].din, $sformatf("vec%0d", i));
      check8($sformatf("tbl%0d uo_out", i), bus.uo_out, tbl[i].exp_uo);
      check8($sformatf("tbl%0d uio_out", i), bus.uio_out, tbl[i].exp_uio);
    end

    // Full: delay 15, nine writes, ninth dropped, drain yields 01..08.
    apply(0, 0, 1, 0, 8'h0F, "full cfg");
    for (int i = 1; i <= 9; i++) begin
      apply(1, 0, 0, 0, 8'(i), "full wr");
      if (i == 8) check8("full flag", {7'd0, bus.uio_out[4]}, 8'd1);
    end
    check8("full after drop", {7'd0, bus.uio_out[4]}, 8'd1);
    got.delete();
    for (int i = 0; i < 40; i++) begin
      apply(0, 1, 0, 0, 8'h00, "drain");
      if (bus.uio_out[7]) got.push_back(bus.uo_out);
    end
    check8("drain count", 8'(got.size()), 8'd8);
    for (int i = 0; i < got.size() && i < 8; i++) begin
      check8($sformatf("drain data%0d", i), got[i], 8'(i + 1));
    end

    // Simultaneous write+read with three ready entries.
    apply(0, 0, 1, 0, 8'h00, "sim cfg");
    apply(1, 0, 0, 0, 8'hAA, "sim wr");
    apply(1, 0, 0, 0, 8'hBB, "sim wr");
    apply(1, 0, 0, 0, 8'hCC, "sim wr");
    apply(1, 1, 0, 0, 8'hDD, "sim wrrd");
    check8("sim head out", bus.uo_out, 8'hAA);
    apply(0, 1, 0, 0, 8'h00, "sim rd");
    check8("sim rd1", bus.uo_out, 8'hBB);
    apply(0, 1, 0, 0, 8'h00, "sim rd");
    apply(0, 1, 0, 0, 8'h00, "sim rd");
    check8("sim tail", bus.uo_out, 8'hDD);
    check8("sim empty", bus.uio_out, 8'hA0);

    // Pointer wrap: 20 entries streamed through with delay 0.
    apply(1, 0, 0, 0, 8'h40, "wrap prime");
    for (int i = 1; i < 20; i++) begin
      apply(1, 1, 0, 0, 8'(8'h40 + i), "wrap");
      check8($sformatf("wrap out%0d", i), bus.uo_out, 8'(8'h40 + i - 1));
    end
    apply(0, 1, 0, 0, 8'h00, "wrap last");

    // Clear beats cfg and wr; delay (15) must survive.
    apply(0, 0, 1, 0, 8'h0F, "clr cfg");
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 0, 8'(8'h90 + i), "clr fill");
    apply(1, 0, 1, 1, 8'h00, "clr prio");
    check8("clr empty", bus.uio_out, 8'h20);
    check8("clr uo kept", bus.uo_out, 8'h53);
    apply(1, 0, 0, 0, 8'h77, "clr post wr");
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 8'h00, "clr post wait");
    check8("clr delay kept", {7'd0, bus.uio_out[6]}, 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
            8'($urandom), "rand");
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
    bus.uio_in = 8'h00;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_model("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 29) == 0, 1'b0, 8'($urandom), "rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
